rat_2way: RTL and testbench

- Two-wide register alias table for the rename stage.
- Maps architectural registers (ARF) to physical registers (PRF) for two instructions per cycle.
- Requests new PRF entries for destinations, with intra-bundle forwarding from instruction 1 to instruction 2.
- On a branch mispredict, restores the map from the retirement RAT and reports the PRF entries freed by the restore.

---
 rtl/rat_2way_pkg.sv | 13 +
 rtl/rat_lookup.sv | 28 ++
 rtl/rat_2way.sv | 148 ++++++++++++++
 tb/tb_rat_2way.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rat_2way_pkg.sv
// Shared sizes and index types for the two-wide rename alias table.
// Imported by the RAT top level and by its per-operand lookup slice.
package rat_2way_pkg;

  localparam int ARF_SIZE = 32;
  localparam int PRF_SIZE = 64;
  localparam int ARF_W    = $clog2(ARF_SIZE);
  localparam int PRF_W    = $clog2(PRF_SIZE);

  typedef logic [ARF_W-1:0] arf_idx_t;
  typedef logic [PRF_W-1:0] prf_idx_t;

endpackage

// File: rtl/rat_lookup.sv
// One renamed source operand: immediate gating, intra-bundle
// forwarding from slot 1, and zeroing while a mispredict flushes.
module rat_lookup
  import rat_2way_pkg::*;
(
  input  prf_idx_t [ARF_SIZE-1:0] map,
  input  arf_idx_t                arf_idx,
  input  logic                    imm,
  input  logic                    mis,
  input  logic                    fwd_en,
  input  arf_idx_t                fwd_dest,
  input  prf_idx_t                fwd_idx,
  output prf_idx_t                prf_idx
);

  // flush and immediates dominate, then the same-bundle producer
  always_comb begin
    prf_idx = '0;
    if (mis || imm) begin
      prf_idx = '0;
    end else if (fwd_en && (arf_idx == fwd_dest)) begin
      prf_idx = fwd_idx;
    end else begin
      prf_idx = map[arf_idx];
    end
  end

endmodule

// File: rtl/rat_2way.sv
// Two-wide register alias table with mispredict restore from the
// retirement map and reporting of the physical entries it drops.
module rat_2way
  import rat_2way_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    inst1_enable,
  input  logic                    inst2_enable,
  input  arf_idx_t                opa_ARF_idx1,
  input  arf_idx_t                opb_ARF_idx1,
  input  arf_idx_t                dest_ARF_idx1,
  input  arf_idx_t                opa_ARF_idx2,
  input  arf_idx_t                opb_ARF_idx2,
  input  arf_idx_t                dest_ARF_idx2,
  input  logic                    dest_rename_sig1,
  input  logic                    dest_rename_sig2,
  input  logic                    opa_valid_in1,
  input  logic                    opb_valid_in1,
  input  logic                    opa_valid_in2,
  input  logic                    opb_valid_in2,
  input  logic                    mispredict_sig1,
  input  logic                    mispredict_sig2,
  input  prf_idx_t [ARF_SIZE-1:0] mispredict_up_idx,
  input  logic                    PRF_rename_valid1,
  input  logic                    PRF_rename_valid2,
  input  prf_idx_t                PRF_rename_idx1,
  input  prf_idx_t                PRF_rename_idx2,
  output prf_idx_t                opa_PRF_idx1,
  output prf_idx_t                opb_PRF_idx1,
  output prf_idx_t                opa_PRF_idx2,
  output prf_idx_t                opb_PRF_idx2,
  output logic                    request1,
  output logic                    request2,
  output logic                    RAT_allo_halt1,
  output logic                    RAT_allo_halt2,
  output logic [PRF_SIZE-1:0]     PRF_free_list_out,
  output logic                    PRF_free_valid
);

  prf_idx_t [ARF_SIZE-1:0] map_q, map_d;
  logic     [ARF_SIZE-1:0] valid_q, valid_d;

  logic mis;
  logic ren1;
  logic ren2;

  // allocation handshake; slot 2 never renames past a stalled slot 1
  always_comb begin
    mis            = mispredict_sig1 | mispredict_sig2;
    request1       = inst1_enable & dest_rename_sig1 & ~mis;
    request2       = inst2_enable & dest_rename_sig2 & ~mis;
    RAT_allo_halt1 = request1 & ~PRF_rename_valid1;
    RAT_allo_halt2 = RAT_allo_halt1
                   | (request2 & ~PRF_rename_valid2);
    ren1           = request1 & PRF_rename_valid1;
    ren2           = request2 & PRF_rename_valid2
                   & ~RAT_allo_halt1;
  end

  rat_lookup u_opa1 (
    .map      (map_q),
    .arf_idx  (opa_ARF_idx1),
    .imm      (opa_valid_in1),
    .mis      (mis),
    .fwd_en   (1'b0),
    .fwd_dest ('0),
    .fwd_idx  ('0),
    .prf_idx  (opa_PRF_idx1)
  );

  rat_lookup u_opb1 (
    .map      (map_q),
    .arf_idx  (opb_ARF_idx1),
    .imm      (opb_valid_in1),
    .mis      (mis),
    .fwd_en   (1'b0),
    .fwd_dest ('0),
    .fwd_idx  ('0),
    .prf_idx  (opb_PRF_idx1)
  );

  rat_lookup u_opa2 (
    .map      (map_q),
    .arf_idx  (opa_ARF_idx2),
    .imm      (opa_valid_in2),
    .mis      (mis),
    .fwd_en   (ren1),
    .fwd_dest (dest_ARF_idx1),
    .fwd_idx  (PRF_rename_idx1),
    .prf_idx  (opa_PRF_idx2)
  );

  rat_lookup u_opb2 (
    .map      (map_q),
    .arf_idx  (opb_ARF_idx2),
    .imm      (opb_valid_in2),
    .mis      (mis),
    .fwd_en   (ren1),
    .fwd_dest (dest_ARF_idx1),
    .fwd_idx  (PRF_rename_idx1),
    .prf_idx  (opb_PRF_idx2)
  );

  // speculative entries that differ from the retirement map get freed
  always_comb begin
    PRF_free_list_out = '0;
    PRF_free_valid    = mis;
    if (mis) begin
      for (int i = 0; i < ARF_SIZE; i++) begin
        if (valid_q[i] && (map_q[i] != mispredict_up_idx[i])) begin
          PRF_free_list_out[map_q[i]] = 1'b1;
        end
      end
    end
  end

  // restore on mispredict, else commit renames with slot 2 last
  always_comb begin
    map_d   = map_q;
    valid_d = valid_q;
    if (mis) begin
      map_d   = mispredict_up_idx;
      valid_d = '1;
    end else begin
      if (ren1) begin
        map_d[dest_ARF_idx1]   = PRF_rename_idx1;
        valid_d[dest_ARF_idx1] = 1'b1;
      end
      if (ren2) begin
        map_d[dest_ARF_idx2]   = PRF_rename_idx2;
        valid_d[dest_ARF_idx2] = 1'b1;
      end
    end
  end

  // map and valid state registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      map_q   <= '0;
      valid_q <= '0;
    end else begin
      map_q   <= map_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_rat_2way.sv
// Scoreboard bench for rat_2way: directed rename/restore walk, then
// random bundles checked against an array-based alias-table model.
module tb_rat_2way;

  logic clock = 1'b0;
  logic reset;
  logic inst1_enable, inst2_enable;
  logic [4:0] opa_ARF_idx1, opb_ARF_idx1, dest_ARF_idx1;
  logic [4:0] opa_ARF_idx2, opb_ARF_idx2, dest_ARF_idx2;
  logic dest_rename_sig1, dest_rename_sig2;
  logic opa_valid_in1, opb_valid_in1, opa_valid_in2, opb_valid_in2;
  logic mispredict_sig1, mispredict_sig2;
  logic [31:0][5:0] mispredict_up_idx;
  logic PRF_rename_valid1, PRF_rename_valid2;
  logic [5:0] PRF_rename_idx1, PRF_rename_idx2;
  logic [5:0] opa_PRF_idx1, opb_PRF_idx1, opa_PRF_idx2, opb_PRF_idx2;
  logic request1, request2, RAT_allo_halt1, RAT_allo_halt2;
  logic [63:0] PRF_free_list_out;
  logic PRF_free_valid;

  always #5 clock = ~clock;

  rat_2way dut (
    .clock             (clock),
    .reset             (reset),
    .inst1_enable      (inst1_enable),
    .inst2_enable      (inst2_enable),
    .opa_ARF_idx1      (opa_ARF_idx1),
    .opb_ARF_idx1      (opb_ARF_idx1),
    .dest_ARF_idx1     (dest_ARF_idx1),
    .opa_ARF_idx2      (opa_ARF_idx2),
    .opb_ARF_idx2      (opb_ARF_idx2),
    .dest_ARF_idx2     (dest_ARF_idx2),
    .dest_rename_sig1  (dest_rename_sig1),
    .dest_rename_sig2  (dest_rename_sig2),
    .opa_valid_in1     (opa_valid_in1),
    .opb_valid_in1     (opb_valid_in1),
    .opa_valid_in2     (opa_valid_in2),
    .opb_valid_in2     (opb_valid_in2),
    .mispredict_sig1   (mispredict_sig1),
    .mispredict_sig2   (mispredict_sig2),
    .mispredict_up_idx (mispredict_up_idx),
    .PRF_rename_valid1 (PRF_rename_valid1),
    .PRF_rename_valid2 (PRF_rename_valid2),
    .PRF_rename_idx1   (PRF_rename_idx1),
    .PRF_rename_idx2   (PRF_rename_idx2),
    .opa_PRF_idx1      (opa_PRF_idx1),
    .opb_PRF_idx1      (opb_PRF_idx1),
    .opa_PRF_idx2      (opa_PRF_idx2),
    .opb_PRF_idx2      (opb_PRF_idx2),
    .request1          (request1),
    .request2          (request2),
    .RAT_allo_halt1    (RAT_allo_halt1),
    .RAT_allo_halt2    (RAT_allo_halt2),
    .PRF_free_list_out (PRF_free_list_out),
    .PRF_free_valid    (PRF_free_valid)
  );

  typedef struct {
    bit         rst;
    bit         e1, e2, r1, r2;
    logic [4:0] a1, b1, d1, a2, b2, d2;
    bit         va1, vb1, va2, vb2;
    bit         m1, m2, pv1, pv2;
    logic [5:0] pi1, pi2;
    logic [31:0][5:0] up;
  } stim_t;

  typedef struct {
    logic [5:0]  oa1, ob1, oa2, ob2;
    bit          q1, q2, h1, h2, fv;
    logic [63:0] fl;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // reference model: the architectural-to-physical table itself
  int map_m[32];
  bit vld_m[32];

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, req);
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.va1 = 1; s.vb1 = 1; s.va2 = 1; s.vb2 = 1;
    return s;
  endfunction

  function automatic logic [5:0] lookup(logic [4:0] a, bit imm,
                                        bit mis, bit fwd,
                                        logic [4:0] fd, logic [5:0] fi);
    if (mis || imm) return 6'd0;
    if (fwd && a == fd) return fi;
    return 6'(map_m[a]);
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit mis, ren1, ren2;
    reset = !s.rst;
    inst1_enable = s.e1; inst2_enable = s.e2;
    opa_ARF_idx1 = s.a1; opb_ARF_idx1 = s.b1; dest_ARF_idx1 = s.d1;
    opa_ARF_idx2 = s.a2; opb_ARF_idx2 = s.b2; dest_ARF_idx2 = s.d2;
    dest_rename_sig1 = s.r1; dest_rename_sig2 = s.r2;
    opa_valid_in1 = s.va1; opb_valid_in1 = s.vb1;
    opa_valid_in2 = s.va2; opb_valid_in2 = s.vb2;
    mispredict_sig1 = s.m1; mispredict_sig2 = s.m2;
    mispredict_up_idx = s.up;
    PRF_rename_valid1 = s.pv1; PRF_rename_valid2 = s.pv2;
    PRF_rename_idx1 = s.pi1; PRF_rename_idx2 = s.pi2;
    if (s.rst) begin
      foreach (map_m[i]) begin map_m[i] = 0; vld_m[i] = 0; end
    end
    mis  = s.m1 | s.m2;
    e.q1 = s.e1 & s.r1 & !mis;
    e.q2 = s.e2 & s.r2 & !mis;
    e.h1 = e.q1 & !s.pv1;
    e.h2 = e.h1 | (e.q2 & !s.pv2);
    ren1 = e.q1 & s.pv1;
    ren2 = e.q2 & s.pv2 & !e.h1;
    e.oa1 = lookup(s.a1, s.va1, mis, 0, 0, 0);
    e.ob1 = lookup(s.b1, s.vb1, mis, 0, 0, 0);
    e.oa2 = lookup(s.a2, s.va2, mis, ren1, s.d1, s.pi1);
    e.ob2 = lookup(s.b2, s.vb2, mis, ren1, s.d1, s.pi1);
    e.fv = mis;
    e.fl = '0;
    if (mis) begin
      for (int i = 0; i < 32; i++)
        if (vld_m[i] && map_m[i] != int'(s.up[i])) e.fl[map_m[i]] = 1'b1;
    end
    exp_q.push_back(e);
    if (!s.rst) begin
      if (mis) begin
        for (int i = 0; i < 32; i++) begin
          map_m[i] = int'(s.up[i]); vld_m[i] = 1;
        end
      end else begin
        if (ren1) begin map_m[s.d1] = int'(s.pi1); vld_m[s.d1] = 1; end
        if (ren2) begin map_m[s.d2] = int'(s.pi2); vld_m[s.d2] = 1; end
      end
    end
    @(posedge clock);
    #1;
  endtask

  // monitor: outputs are combinational, so each cycle presents a result
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("opa1", 64'(opa_PRF_idx1), 64'(e.oa1));
        chk("opb1", 64'(opb_PRF_idx1), 64'(e.ob1));
        chk("opa2", 64'(opa_PRF_idx2), 64'(e.oa2));
        chk("opb2", 64'(opb_PRF_idx2), 64'(e.ob2));
        chk("req1", 64'(request1), 64'(e.q1));
        chk("req2", 64'(request2), 64'(e.q2));
        chk("halt1", 64'(RAT_allo_halt1), 64'(e.h1));
        chk("halt2", 64'(RAT_allo_halt2), 64'(e.h2));
        chk("free_valid", 64'(PRF_free_valid), 64'(e.fv));
        chk("free_list", PRF_free_list_out, e.fl);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b0;
    @(posedge clock);
    #1;
    s = idle(); s.rst = 1;
    apply(s);
    // dest0 -> 12, dest1 -> 3
    s = idle(); s.e1 = 1; s.e2 = 1; s.r1 = 1; s.r2 = 1;
    s.pv1 = 1; s.pv2 = 1;
    s.d1 = 0; s.pi1 = 12; s.d2 = 1; s.pi2 = 3;
    apply(s);
    s.d1 = 2; s.pi1 = 9; s.d2 = 3; s.pi2 = 10;
    apply(s);
    s.d1 = 4; s.pi1 = 5; s.r2 = 0;
    apply(s);
    // restore: frees PRF 10 and 12
    s = idle(); s.m2 = 1;
    s.up[0] = 8; s.up[1] = 3; s.up[2] = 9; s.up[3] = 6; s.up[4] = 5;
    apply(s);
    s = idle(); s.va1 = 0; s.vb1 = 0; s.va2 = 0; s.vb2 = 0;
    s.e1 = 1; s.e2 = 1; s.r1 = 1; s.r2 = 1; s.pv1 = 1; s.pv2 = 1;
    s.a1 = 1; s.b1 = 4; s.d1 = 2; s.pi1 = 0;
    s.a2 = 0; s.b2 = 2; s.d2 = 0; s.pi2 = 1;
    apply(s);
    // slot-1 stall blocks both slots
    s.pv1 = 0; s.d1 = 1; s.pi1 = 40; s.d2 = 4; s.pi2 = 41;
    apply(s);
    // same destination: slot 2 wins
    s.pv1 = 1; s.d1 = 5; s.pi1 = 20; s.d2 = 5; s.pi2 = 21;
    s.a1 = 1; s.b1 = 4; s.a2 = 7; s.b2 = 7;
    apply(s);
    s = idle(); s.va1 = 0; s.a1 = 5;
    apply(s);
    // mid-run reset, then a mispredict frees nothing
    s = idle(); s.rst = 1; s.va1 = 0; s.vb1 = 0; s.a1 = 5; s.b1 = 2;
    apply(s);
    s = idle(); s.m1 = 1;
    for (int i = 0; i < 32; i++) s.up[i] = 6'(i + 1);
    apply(s);
    // randomized bundles over a narrow register window
    for (int n = 0; n < 400; n++) begin
      s = idle();
      s.rst = ($urandom_range(0, 59) == 0);
      s.e1 = $urandom_range(0, 3) != 0; s.e2 = $urandom_range(0, 3) != 0;
      s.r1 = $urandom_range(0, 3) != 0; s.r2 = $urandom_range(0, 3) != 0;
      s.a1 = 5'($urandom_range(0, 7)); s.b1 = 5'($urandom_range(0, 7));
      s.d1 = 5'($urandom_range(0, 7)); s.a2 = 5'($urandom_range(0, 7));
      s.b2 = 5'($urandom_range(0, 7)); s.d2 = 5'($urandom_range(0, 7));
      s.va1 = $urandom_range(0, 3) == 0; s.vb1 = $urandom_range(0, 3) == 0;
      s.va2 = $urandom_range(0, 3) == 0; s.vb2 = $urandom_range(0, 3) == 0;
      s.m1 = $urandom_range(0, 15) == 0; s.m2 = $urandom_range(0, 15) == 0;
      s.pv1 = $urandom_range(0, 4) != 0; s.pv2 = $urandom_range(0, 4) != 0;
      s.pi1 = 6'($urandom); s.pi2 = 6'($urandom);
      for (int i = 0; i < 32; i++) s.up[i] = 6'($urandom);
      apply(s);
    end
    @(negedge clock);
    #1;
    n_chk++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
